// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the hardwired control sequencer:
// state enum, opcode values, ALU function codes and the strobe bundle.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'd0;
  localparam logic [4:0] ALU_ADD = 5'd3;
  localparam logic [4:0] ALU_SUB = 5'd4;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic c_out;
    logic zlo_out;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic write;
  } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: IR/memory status in, control strobes out.
// Carries Step only when CTRL_SEQ_STEP_DEBUG_EN is defined.
interface control_sequencer_if #(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 5
);
  logic [DATA_W-1:0]   IRregister;
  logic                Mem_ready;
`ifdef CTRL_SEQ_STEP_DEBUG_EN
  logic                Step;
`endif
  logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic Cout, ZLOout, Gra, Grb, Grc, Rin, Rout, BAout, write;
  logic [ALU_OP_W-1:0] ALU_op;
  logic                Run, Illegal, Mem_timeout;

  modport master (
    input  IRregister, Mem_ready,
`ifdef CTRL_SEQ_STEP_DEBUG_EN
    input  Step,
`endif
    output PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    output Cout, ZLOout, Gra, Grb, Grc, Rin, Rout, BAout, write,
    output ALU_op, Run, Illegal, Mem_timeout
  );

  modport slave (
    output IRregister, Mem_ready,
`ifdef CTRL_SEQ_STEP_DEBUG_EN
    output Step,
`endif
    input  PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin,
    input  Cout, ZLOout, Gra, Grb, Grc, Rin, Rout, BAout, write,
    input  ALU_op, Run, Illegal, Mem_timeout
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Cycle counter for memory wait states; timeout fires on the WAIT_MAX-th
// consecutive not-ready cycle so the caller can leave instead of waiting again.
module mem_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign timeout = en && (cnt_q == 8'(WAIT_MAX - 1));
endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the datapath: fetch, decode, execute
// with memory wait/timeout. CTRL_SEQ_STEP_DEBUG_EN adds single-instruction stepping.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPCODE_W = 5,
  parameter int ALU_OP_W = 5,
  parameter int WAIT_MAX = 15
) (
  input  logic                Clock,
  input  logic                Reset_n,
  control_sequencer_if.master bus
);
  localparam logic [OPCODE_W-1:0] C_LD   = OPCODE_W'(OP_LD);
  localparam logic [OPCODE_W-1:0] C_LDI  = OPCODE_W'(OP_LDI);
  localparam logic [OPCODE_W-1:0] C_ST   = OPCODE_W'(OP_ST);
  localparam logic [OPCODE_W-1:0] C_ADD  = OPCODE_W'(OP_ADD);
  localparam logic [OPCODE_W-1:0] C_SUB  = OPCODE_W'(OP_SUB);
  localparam logic [OPCODE_W-1:0] C_HALT = OPCODE_W'(OP_HALT);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d, op_ir;
  logic                idle_q, idle_d;
  logic                tmo_q, tmo_d;
  strobes_t            sb;
  logic [ALU_OP_W-1:0] alu;
  logic                illegal, wait_st, timeout, go;

  assign op_ir = bus.IRregister[DATA_W-1 -: OPCODE_W];

  // idle_q marks the cycle(s) spent in reset so strobes stay low there
  assign wait_st = !idle_q && (state_q == S_T1 ||
                               (state_q == S_T6 && op_q == C_LD) ||
                               (state_q == S_T7 && op_q == C_ST));

`ifdef CTRL_SEQ_STEP_DEBUG_EN
  logic armed_q, armed_d;

  // Step arms one pass out of T0; the flag drops as soon as T0 is left
  always_comb begin
    armed_d = 1'b0;
    if (!idle_q && state_q == S_T0 && !armed_q) armed_d = bus.Step;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) armed_q <= 1'b0;
    else          armed_q <= armed_d;
  end

  assign go = armed_q;
`else
  assign go = 1'b1;
`endif

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
    .clk    (Clock),
    .rst_n  (Reset_n),
    .clr    (!wait_st || bus.Mem_ready),
    .en     (wait_st && !bus.Mem_ready),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    idle_d  = 1'b0;
    sb      = '0;
    alu     = ALU_OP_W'(ALU_NOP);
    illegal = 1'b0;
    if (idle_q) begin
      state_d = S_T0;
    end else begin
      case (state_q)
        S_T0: if (go) begin
          sb.pc_out = 1'b1; sb.mar_in = 1'b1; sb.inc_pc = 1'b1; sb.z_in = 1'b1;
          alu = ALU_OP_W'(ALU_ADD);
          state_d = S_T1;
        end
        S_T1: begin
          sb.zlo_out = 1'b1; sb.pc_in = 1'b1; sb.read = 1'b1; sb.mdr_in = 1'b1;
          state_d = S_T2;
        end
        S_T2: begin
          sb.mdr_out = 1'b1; sb.ir_in = 1'b1;
          state_d = S_T3;
        end
        S_T3: begin
          // IR is only valid from here on; latch the opcode for T4..T7
          op_d    = op_ir;
          state_d = S_T4;
          case (op_ir)
            C_LD, C_LDI, C_ST: begin sb.grb = 1'b1; sb.ba_out = 1'b1; sb.y_in = 1'b1; end
            C_ADD, C_SUB:      begin sb.grb = 1'b1; sb.r_out = 1'b1; sb.y_in = 1'b1; end
            C_HALT:            state_d = S_HALT;
            default:           begin illegal = 1'b1; state_d = S_T0; end
          endcase
        end
        S_T4: begin
          sb.z_in = 1'b1;
          state_d = S_T5;
          if (op_q == C_ADD || op_q == C_SUB) begin
            sb.grc = 1'b1; sb.r_out = 1'b1;
            alu = (op_q == C_SUB) ? ALU_OP_W'(ALU_SUB) : ALU_OP_W'(ALU_ADD);
          end else begin
            sb.c_out = 1'b1;
            alu = ALU_OP_W'(ALU_ADD);
          end
        end
        S_T5: begin
          sb.zlo_out = 1'b1;
          if (op_q == C_LD || op_q == C_ST) begin
            sb.mar_in = 1'b1; state_d = S_T6;
          end else begin
            sb.gra = 1'b1; sb.r_in = 1'b1; state_d = S_T0;
          end
        end
        S_T6: begin
          sb.mdr_in = 1'b1;
          state_d = S_T7;
          if (op_q == C_ST) begin sb.gra = 1'b1; sb.r_out = 1'b1; end
          else              sb.read = 1'b1;
        end
        S_T7: begin
          state_d = S_T0;
          if (op_q == C_ST) sb.write = 1'b1;
          else begin sb.mdr_out = 1'b1; sb.gra = 1'b1; sb.r_in = 1'b1; end
        end
        default: state_d = S_HALT;
      endcase
      if (wait_st && !bus.Mem_ready) begin
        state_d = timeout ? S_HALT : state_q;
        tmo_d   = tmo_q | timeout;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= S_T0;
      op_q    <= '0;
      idle_q  <= 1'b1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.PCout       = sb.pc_out;
  assign bus.MARin       = sb.mar_in;
  assign bus.IncPC       = sb.inc_pc;
  assign bus.Zin         = sb.z_in;
  assign bus.PCin        = sb.pc_in;
  assign bus.Read        = sb.read;
  assign bus.MDRin       = sb.mdr_in;
  assign bus.MDRout      = sb.mdr_out;
  assign bus.IRin        = sb.ir_in;
  assign bus.Yin         = sb.y_in;
  assign bus.Cout        = sb.c_out;
  assign bus.ZLOout      = sb.zlo_out;
  assign bus.Gra         = sb.gra;
  assign bus.Grb         = sb.grb;
  assign bus.Grc         = sb.grc;
  assign bus.Rin         = sb.r_in;
  assign bus.Rout        = sb.r_out;
  assign bus.BAout       = sb.ba_out;
  assign bus.write       = sb.write;
  assign bus.ALU_op      = alu;
  assign bus.Illegal     = illegal;
  assign bus.Run         = !idle_q && (state_q != S_HALT);
  assign bus.Mem_timeout = tmo_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction micro-step tables
// with random memory latency, checked cycle by cycle.
module tb_control_sequencer;
  import ctrl_pkg::*;

  localparam int WAIT_MAX = 15;

  localparam logic [18:0] PCO  = 19'd1 << 18, MARI = 19'd1 << 17, INC  = 19'd1 << 16;
  localparam logic [18:0] ZIN  = 19'd1 << 15, PCI  = 19'd1 << 14, RD   = 19'd1 << 13;
  localparam logic [18:0] MDRI = 19'd1 << 12, MDRO = 19'd1 << 11, IRI  = 19'd1 << 10;
  localparam logic [18:0] YIN  = 19'd1 << 9,  COUT = 19'd1 << 8,  ZLO  = 19'd1 << 7;
  localparam logic [18:0] GRA  = 19'd1 << 6,  GRB  = 19'd1 << 5,  GRC  = 19'd1 << 4;
  localparam logic [18:0] RIN  = 19'd1 << 3,  ROUT = 19'd1 << 2,  BAO  = 19'd1 << 1;
  localparam logic [18:0] WR   = 19'd1;

  typedef struct {
    logic [18:0] sb;
    logic [4:0]  alu;
    logic        wt;
    logic        ill;
    int          t;
  } step_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.DATA_W(32), .ALU_OP_W(5)) bus ();

  control_sequencer #(
    .DATA_W(32), .OPCODE_W(5), .ALU_OP_W(5), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .Clock  (clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  logic [26:0] obs;
  assign obs = {bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.PCin, bus.Read, bus.MDRin,
                bus.MDRout, bus.IRin, bus.Yin, bus.Cout, bus.ZLOout, bus.Gra, bus.Grb,
                bus.Grc, bus.Rin, bus.Rout, bus.BAout, bus.write,
                bus.ALU_op, bus.Illegal, bus.Run, bus.Mem_timeout};

  int     n_chk = 0;
  int     n_err = 0;
  step_t  seq[$];
  logic   halt_after;
  logic   tmo_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void push(logic [18:0] sb, logic [4:0] alu, logic wt, logic ill, int t);
    step_t s;
    s.sb = sb; s.alu = alu; s.wt = wt; s.ill = ill; s.t = t;
    seq.push_back(s);
  endfunction

  // Expected micro-steps of one instruction, straight from the instruction table
  function automatic void build_seq(logic [4:0] op);
    seq.delete();
    halt_after = 1'b0;
`ifdef CTRL_SEQ_STEP_DEBUG_EN
    push(19'd0, ALU_NOP, 1'b0, 1'b0, -1);
`endif
    push(PCO | MARI | INC | ZIN, ALU_ADD, 1'b0, 1'b0, 0);
    push(ZLO | PCI | RD | MDRI, ALU_NOP, 1'b1, 1'b0, 1);
    push(MDRO | IRI, ALU_NOP, 1'b0, 1'b0, 2);
    case (op)
      OP_LD, OP_LDI, OP_ST: begin
        push(GRB | BAO | YIN, ALU_NOP, 1'b0, 1'b0, 3);
        push(COUT | ZIN, ALU_ADD, 1'b0, 1'b0, 4);
        if (op == OP_LDI) push(ZLO | GRA | RIN, ALU_NOP, 1'b0, 1'b0, 5);
        else begin
          push(ZLO | MARI, ALU_NOP, 1'b0, 1'b0, 5);
          if (op == OP_LD) begin
            push(RD | MDRI, ALU_NOP, 1'b1, 1'b0, 6);
            push(MDRO | GRA | RIN, ALU_NOP, 1'b0, 1'b0, 7);
          end else begin
            push(GRA | ROUT | MDRI, ALU_NOP, 1'b0, 1'b0, 6);
            push(WR, ALU_NOP, 1'b1, 1'b0, 7);
          end
        end
      end
      OP_ADD, OP_SUB: begin
        push(GRB | ROUT | YIN, ALU_NOP, 1'b0, 1'b0, 3);
        push(GRC | ROUT | ZIN, (op == OP_ADD) ? ALU_ADD : ALU_SUB, 1'b0, 1'b0, 4);
        push(ZLO | GRA | RIN, ALU_NOP, 1'b0, 1'b0, 5);
      end
      OP_HALT: begin
        push(19'd0, ALU_NOP, 1'b0, 1'b0, 3);
        halt_after = 1'b1;
      end
      default: push(19'd0, ALU_NOP, 1'b0, 1'b1, 3);
    endcase
  endfunction

  // Entered at posedge+1 or at a negedge; leaves at posedge+1 with the DUT in T0
  task automatic do_reset();
    Reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset", {5'd0, obs & ~27'h2}, 32'd0);
    Reset_n = 1'b1;
    tmo_exp = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_halt(input int n);
    logic [31:0] r;
    for (int c = 0; c < n; c++) begin
      r = $urandom();
      bus.IRregister = r;
      bus.Mem_ready  = r[0];
      @(negedge clk);
      check("halt", {5'd0, obs}, {5'd0, 24'd0, 1'b0, 1'b0, tmo_exp});
      @(posedge clk); #1;
    end
  endtask

  // d_fetch / d_exec: not-ready cycles before Mem_ready in T1 / the execute wait;
  // a delay >= WAIT_MAX never asserts ready. abort_t: T-state at which reset hits.
  task automatic run_instr(input logic [31:0] ir, input int d_fetch, input int d_exec,
                           input int abort_t);
    logic [31:0] r;
    int d, lim;
    build_seq(ir[31:27]);
    foreach (seq[i]) begin
      d   = !seq[i].wt ? 0 : (seq[i].t == 1 ? d_fetch : d_exec);
      lim = (d < WAIT_MAX) ? d : WAIT_MAX - 1;
      for (int k = 0; k <= lim; k++) begin
        r = $urandom();
        bus.IRregister = (seq[i].t == 3) ? ir : r;
        bus.Mem_ready  = seq[i].wt ? (k == d) : r[0];
        @(negedge clk);
        check($sformatf("ir%h_t%0d_c%0d", ir, seq[i].t, k), {5'd0, obs},
              {5'd0, seq[i].sb, seq[i].alu, seq[i].ill, 1'b1, tmo_exp});
        if (seq[i].t == abort_t) begin
          do_reset();
          return;
        end
        @(posedge clk); #1;
      end
      if (seq[i].wt && d >= WAIT_MAX) begin
        tmo_exp = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    logic [31:0] r;
    logic [4:0]  op;
    int          sel;
    tmo_exp        = 1'b0;
    bus.IRregister = '0;
    bus.Mem_ready  = 1'b0;
`ifdef CTRL_SEQ_STEP_DEBUG_EN
    bus.Step = 1'b1;
`endif
    do_reset();

    run_instr(32'h08800075, 0, 0, -1);            // ldi, ready high throughout
    run_instr(32'h00080045, 0, 3, -1);            // ld, T6 stretched to 4 cycles
    run_instr(32'hF8000000, 0, 0, -1);            // opcode 0x1F
    run_instr(32'h18443000, 2, 0, -1);            // add with slow fetch
    run_instr(32'h20443000, 0, 0, -1);            // sub

    repeat (40) begin
      r   = $urandom();
      sel = $urandom_range(0, 5);
      if (sel < 5) op = 5'(sel);
      else begin
        op = 5'($urandom_range(5, 31));
        if (op == OP_HALT) op = 5'd31;
      end
      run_instr({op, r[26:0]}, $urandom_range(0, 3), $urandom_range(0, 4), -1);
    end

    run_instr(32'h00080045, 0, 0, 5);             // reset lands in ld T5
    run_instr(32'h08800075, 1, 0, -1);

    run_instr(32'h10000000, 0, WAIT_MAX, -1);     // st, memory never ready
    check_halt(3);
    do_reset();                                   // reset from HALT clears the flag
    run_instr(32'h08800075, 0, 0, -1);
    run_instr(32'hD8000000, 0, 0, -1);            // halt
    check_halt(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
